mod_data_mem_bridge: RTL
========================

# mod_data_mem_bridge

Bridge between the single-cycle processor's combinational data-memory port and a multi-cycle req/ack memory bus. It captures a load or store request and stalls the core through its `hold` input until the bus acknowledges. It then hands the load data back for exactly one commit cycle. It sits directly downstream of the processor's `data_address`/`write_data`/`mem_read`/`mem_write` outputs and feeds its `data` and `hold` inputs.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in BUSY waiting for `bus_ack`.
- `ERR_DATA`, default 32'hDEAD_BEEF: load data returned on a timeout.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_mem_read` in 1: load request from the core.
- `cpu_mem_write` in 1: store request from the core.
- `cpu_address` in 32: data address from the core.
- `cpu_write_data` in 32: store data from the core.
- `cpu_read_data` out 32: load data to the core's `data` input.
- `cpu_hold` out 1: stall to the core's `hold` input.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 = write, registered.
- `bus_addr` out 32: registered bus address.
- `bus_wdata` out 32: registered bus write data.
- `bus_ack` in 1: one-cycle completion strobe from memory.
- `bus_rdata` in 32: read data, valid when `bus_ack` = 1.
- `err_clear` in 1: synchronous clear of the sticky error flags.
- `err_timeout` out 1: sticky timeout flag.
- `err_misalign` out 1: sticky misalignment flag (see Configuration).

## Operation
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - With `cpu_mem_read | cpu_mem_write` = 1: latch address, write data and direction into the `bus_*` registers, set `bus_req` = 1, clear the timeout counter, go to BUSY.
  - Otherwise stay in IDLE.
- Read and write both asserted: treated as a write (the control unit never issues this).
- BUSY:
  - `bus_req` stays 1 and `bus_addr`/`bus_we`/`bus_wdata` stay stable.
  - On `bus_ack`: capture `bus_rdata` into the read-data register (loads only; stores leave it unchanged), drop `bus_req`, go to DONE.
  - Counter reaches `TIMEOUT - 1` without ack: drop `bus_req`, load `ERR_DATA` into the read-data register, set `err_timeout`, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE: go to IDLE unconditionally, so each request gets exactly one commit cycle.
- `cpu_hold` (combinational):
  - IDLE: `cpu_mem_read | cpu_mem_write`.
  - BUSY: 1.
  - DONE: 0.
- `cpu_read_data` = read-data register at all times.
- `bus_ack` outside BUSY is ignored.
- `err_clear` clears both sticky flags.
- A set event and `err_clear` in the same cycle: the set wins.
- Timeout counter is 8 bits minimum, sized `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State = IDLE.
  - `bus_req`, `bus_we` = 0.
  - `bus_addr`, `bus_wdata`, `cpu_read_data` = 0.
  - `err_timeout`, `err_misalign` = 0.
  - `cpu_hold` follows the IDLE equation.
- Reset mid-BUSY: `bus_req` drops immediately. Any in-flight ack after reset release is ignored.
- Request seen in cycle 0 (IDLE, hold = 1). `bus_req` is high from cycle 1.
- Ack in cycle k ≥ 1 gives DONE in cycle k+1. The core commits (PC advance, register write) at the end of cycle k+1.
- Zero-wait memory (ack in cycle 1) makes a memory instruction take 3 cycles. Non-memory instructions take 1 cycle and never see hold.
- A back-to-back memory instruction in the cycle after DONE is accepted from IDLE with no bubble.

## Configuration
- `ALIGN_CHECK_EN` defined:
  - In IDLE, a request with `cpu_address[1:0]` ≠ 0 issues no bus transaction.
  - It goes IDLE→DONE with hold = 1 for that cycle and loads 0 into the read-data register.
  - It sets `err_misalign`; a misaligned store writes nothing.
- Not defined:
  - The address is forwarded unchanged.
  - `err_misalign` is tied to 0.
  - No extra logic.

## Test plan
- Load at 0x0000_0010, ack in cycle 1 with rdata 0x1234_5678 → hold = 1, 1, 0 over cycles 0–2. `cpu_read_data` = 0x1234_5678 in cycle 2. `bus_req` high only in cycle 1.
- Store of 0xA5A5_A5A5 to 0x0000_0020, ack after 5 wait cycles → `bus_we` = 1, addr/wdata stable for 6 cycles, single DONE cycle, `cpu_read_data` unchanged.
- Load with no ack, `TIMEOUT` = 8 → `bus_req` drops after 8 BUSY cycles, `cpu_read_data` = 0xDEAD_BEEF, `err_timeout` = 1 until `err_clear`.
- `reset_n` pulsed low during BUSY, ack arriving 2 cycles after release → outputs at reset values immediately, late ack ignored, state IDLE.
- With `ALIGN_CHECK_EN`, load at 0x0000_0006 → no `bus_req`, hold = 1 for one cycle, `cpu_read_data` = 0, `err_misalign` = 1. Without the macro, the same stimulus issues a bus read at 0x0000_0006.

Source files
------------

// File: rtl/mod_data_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// mod_data_mem_bridge_if
//
// Purpose: multi-cycle req/ack memory bus between the data-memory bridge
//          (master) and the memory or memory controller (slave).
//
// Signals:
//   bus_req   master->slave  request, held high until bus_ack or timeout
//   bus_we    master->slave  1 = write, 0 = read
//   bus_addr  master->slave  byte address, stable while bus_req is high
//   bus_wdata master->slave  write data, stable while bus_req is high
//   bus_ack   slave->master  one-cycle completion strobe
//   bus_rdata slave->master  read data, valid while bus_ack is high
// -----------------------------------------------------------------------------
interface mod_data_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mod_data_mem_bridge.sv
// -----------------------------------------------------------------------------
// mod_data_mem_bridge
//
// Purpose: connects the combinational data-memory port of a single-cycle core
//          to a multi-cycle req/ack memory bus. A load or store from the core
//          is captured into registered bus outputs, the core is stalled via
//          o_cpu_hold until the bus acknowledges (or a timeout expires), and
//          the result is presented for exactly one commit cycle (DONE).
//
// Optional feature (compile-time macro ALIGN_CHECK_EN):
//   defined     - requests with i_cpu_address[1:0] != 0 are rejected without a
//                 bus transaction, return 0 and set the sticky o_err_misalign.
//   not defined - addresses are forwarded unchanged, o_err_misalign is 0.
//
// Parameters:
//   TIMEOUT   maximum number of BUSY cycles spent waiting for bus_ack
//   ERR_DATA  load data returned when a request times out
//
// Ports:
//   i_clk             clock, rising edge
//   i_reset_n         asynchronous active-low reset
//   i_cpu_mem_read    load request from the core
//   i_cpu_mem_write   store request from the core (wins over read)
//   i_cpu_address     data address from the core
//   i_cpu_write_data  store data from the core
//   o_cpu_read_data   load data to the core (read-data register)
//   o_cpu_hold        stall to the core (combinational)
//   bus               memory bus, master side
//   i_err_clear       synchronous clear of the sticky error flags
//   o_err_timeout     sticky timeout flag
//   o_err_misalign    sticky misalignment flag
// -----------------------------------------------------------------------------
module mod_data_mem_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_cpu_mem_read,
    input  logic                        i_cpu_mem_write,
    input  logic [31:0]                 i_cpu_address,
    input  logic [31:0]                 i_cpu_write_data,
    output logic [31:0]                 o_cpu_read_data,
    output logic                        o_cpu_hold,
    mod_data_mem_bridge_if.master       bus,
    input  logic                        i_err_clear,
    output logic                        o_err_timeout,
    output logic                        o_err_misalign
);

    // Counter is at least 8 bits wide so small TIMEOUT values still get a
    // sensibly sized, saturating counter.
    localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW > 8) ? CNT_W_RAW : 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    logic               r_bus_req;
    logic               w_bus_req_next;
    logic               r_bus_we;
    logic               w_bus_we_next;
    logic [31:0]        r_bus_addr;
    logic [31:0]        w_bus_addr_next;
    logic [31:0]        r_bus_wdata;
    logic [31:0]        w_bus_wdata_next;
    logic [31:0]        r_rdata;
    logic [31:0]        w_rdata_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_err_timeout;
    logic               w_err_timeout_next;
    logic               w_timeout_set;

    logic               w_cpu_req;
    logic               w_hold;

`ifdef ALIGN_CHECK_EN
    logic               r_err_misalign;
    logic               w_err_misalign_next;
    logic               w_misalign_set;
    logic               w_misaligned;

    assign w_misaligned = (i_cpu_address[1:0] != 2'b00);
`endif

    assign w_cpu_req = i_cpu_mem_read | i_cpu_mem_write;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'd0;
            r_bus_wdata   <= 32'd0;
            r_rdata       <= 32'd0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bus_req     <= w_bus_req_next;
            r_bus_we      <= w_bus_we_next;
            r_bus_addr    <= w_bus_addr_next;
            r_bus_wdata   <= w_bus_wdata_next;
            r_rdata       <= w_rdata_next;
            r_cnt         <= w_cnt_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err_misalign <= 1'b0;
        end else begin
            r_err_misalign <= w_err_misalign_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_bus_req_next   = r_bus_req;
        w_bus_we_next    = r_bus_we;
        w_bus_addr_next  = r_bus_addr;
        w_bus_wdata_next = r_bus_wdata;
        w_rdata_next     = r_rdata;
        w_cnt_next       = r_cnt;
        w_timeout_set    = 1'b0;
        w_hold           = 1'b0;
`ifdef ALIGN_CHECK_EN
        w_misalign_set   = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                // The core is stalled in the very cycle it presents a request;
                // non-memory instructions never see hold.
                w_hold = w_cpu_req;
                if (w_cpu_req) begin
`ifdef ALIGN_CHECK_EN
                    if (w_misaligned) begin
                        // Rejected without touching the bus; the core still
                        // gets its single commit cycle through DONE.
                        w_state_next   = ST_DONE;
                        w_rdata_next   = 32'd0;
                        w_misalign_set = 1'b1;
                    end else begin
`else
                    begin
`endif
                        // A simultaneous read and write is treated as a write.
                        w_bus_req_next   = 1'b1;
                        w_bus_we_next    = i_cpu_mem_write;
                        w_bus_addr_next  = i_cpu_address;
                        w_bus_wdata_next = i_cpu_write_data;
                        w_cnt_next       = '0;
                        w_state_next     = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                w_hold = 1'b1;
                if (bus.bus_ack) begin
                    // Ack wins over a timeout in the same cycle.
                    if (!r_bus_we) begin
                        w_rdata_next = bus.bus_rdata;
                    end
                    w_bus_req_next = 1'b0;
                    w_state_next   = ST_DONE;
                end else if (r_cnt >= CNT_LAST) begin
                    w_bus_req_next = 1'b0;
                    w_rdata_next   = ERR_DATA;
                    w_timeout_set  = 1'b1;
                    w_state_next   = ST_DONE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                // Commit cycle: hold released, back to IDLE unconditionally so
                // a back-to-back request is accepted in the next cycle.
                w_hold       = 1'b0;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_bus_req_next = 1'b0;
            end
        endcase

        // Sticky flags: a set event takes priority over a clear.
        w_err_timeout_next = w_timeout_set | (r_err_timeout & ~i_err_clear);
`ifdef ALIGN_CHECK_EN
        w_err_misalign_next = w_misalign_set | (r_err_misalign & ~i_err_clear);
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.bus_req     = r_bus_req;
    assign bus.bus_we      = r_bus_we;
    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_wdata   = r_bus_wdata;

    assign o_cpu_read_data = r_rdata;
    assign o_cpu_hold      = w_hold;
    assign o_err_timeout   = r_err_timeout;

`ifdef ALIGN_CHECK_EN
    assign o_err_misalign  = r_err_misalign;
`else
    assign o_err_misalign  = 1'b0;
`endif

endmodule
